egd_stream_decoder: RTL and testbench

- Parametrised streaming Exp-Golomb decoder; next generation of the fixed 16-bit egd_top.
- Accepts MSB-first bitstream words over a valid/ready handshake into an internal bit buffer.
- Decodes one syntax element per cycle in ue(v), se(v), te(v) or fixed-length u(n) mode, and returns results over a second valid/ready handshake.
- Sits between the logic-analyser / wishbone bitstream feeder and the slice-header parser.

---
 rtl/egd_stream_decoder_if.sv | 26 ++
 rtl/egd_stream_decoder.sv | 177 +++++++++++++++++
 tb/tb_egd_stream_decoder.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/egd_stream_decoder_if.sv
// Stream bundle for the Exp-Golomb decoder: bitstream words in, decoded
// symbols out, each with its own valid/ready handshake.
interface egd_stream_decoder_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
);
    logic [IN_W-1:0]  in_data;
    logic             in_valid;
    logic             in_ready;
    logic [OUT_W-1:0] out_data;
    logic [5:0]       out_len;
    logic             out_valid;
    logic             out_ready;

    // Feeder / consumer side
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_len, out_valid
    );

    // Decoder side
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_len, out_valid
    );
endinterface

// File: rtl/egd_stream_decoder.sv
// Streaming Exp-Golomb decoder: left-aligned bit buffer fed MSB-first, one
// ue/se/te/u(n) syntax element decoded per cycle into a registered result.
module egd_stream_decoder #(
    parameter int IN_W   = 16,
    parameter int BUF_W  = 64,
    parameter int MAX_LZ = 15,
    parameter int OUT_W  = 32,
    parameter int CNT_W  = 16,
    localparam int FILL_W = $clog2(BUF_W + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    egd_stream_decoder_if.slave      bus,
    input  logic [1:0]               mode,
    input  logic [OUT_W-1:0]         te_range,
    input  logic [4:0]               fixed_len,
    input  logic                     flush,
    output logic                     err,
    output logic [FILL_W-1:0]        fill_level,
    output logic [CNT_W-1:0]         sym_count
);

    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_HOLD, S_ERROR} state_t;

    state_t              state_q, state_d;
    logic [BUF_W-1:0]    buf_q, buf_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic [OUT_W-1:0]    out_data_q, out_data_d;
    logic [5:0]          out_len_q, out_len_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    sym_count_q, sym_count_d;

    logic                lz_found;
    logic [4:0]          lz;
    logic [4:0]          n_eff;
    logic                te_short;
    logic [5:0]          dec_len;
    logic                dec_ok;
    logic                lz_err;
    logic [BUF_W-1:0]    code_bits;
    logic [OUT_W-1:0]    code_num;
    logic [OUT_W-1:0]    dec_val;
    logic                push, retire, can_load, fire, err_set;
    logic [FILL_W-1:0]   fill_mid;
    logic [BUF_W-1:0]    buf_mid;

    // Leading-zero count over the top MAX_LZ+1 buffer bits; bits past fill are always zero
    always_comb begin
        lz_found = 1'b0;
        lz       = '0;
        for (int i = 0; i <= MAX_LZ; i++) begin
            if (!lz_found && buf_q[BUF_W-1-i]) begin
                lz_found = 1'b1;
                lz       = 5'(i);
            end
        end
    end

    // Codeword length, readiness and decoded value for the mode sampled this cycle
    always_comb begin
        n_eff    = (fixed_len == 5'd0 || fixed_len > 5'd16) ? 5'd1 : fixed_len;
        te_short = (mode == 2'b10) && (te_range == OUT_W'(1));
        dec_len  = {lz, 1'b1};
        dec_ok   = 1'b0;
        lz_err   = 1'b0;
        if (mode == 2'b11) begin
            dec_len = {1'b0, n_eff};
        end else if (te_short) begin
            dec_len = 6'd1;
        end
        if (mode == 2'b11 || te_short) begin
            dec_ok = int'(fill_q) >= int'(dec_len);
        end else begin
            dec_ok = lz_found && (int'(fill_q) >= int'(dec_len));
            lz_err = !lz_found && (int'(fill_q) > MAX_LZ);
        end
        // The top L bits of an Exp-Golomb codeword read as 2^N + info, i.e. codeNum + 1
        code_bits = buf_q >> (BUF_W - int'(dec_len));
        code_num  = OUT_W'(code_bits) - OUT_W'(1);
        case (mode)
            2'b01:   dec_val = code_num[0] ? ((code_num + OUT_W'(1)) >> 1)
                                           : (OUT_W'(0) - (code_num >> 1));
            2'b10:   dec_val = te_short ? {{(OUT_W-1){1'b0}}, !buf_q[BUF_W-1]} : code_num;
            2'b11:   dec_val = OUT_W'(code_bits);
            default: dec_val = code_num;
        endcase
    end

    // Handshakes, buffer consume/append, result register and state transitions
    always_comb begin
        push     = bus.in_valid && in_ready_q;
        retire   = out_valid_q && bus.out_ready;
        can_load = !out_valid_q || bus.out_ready;
        fire     = (state_q != S_ERROR) && can_load && dec_ok;
        err_set  = (state_q != S_ERROR) && lz_err;

        fill_mid = fire ? (fill_q - FILL_W'(dec_len)) : fill_q;
        buf_mid  = fire ? (buf_q << dec_len) : buf_q;
        buf_d    = buf_mid;
        fill_d   = fill_mid;
        if (push) begin
            buf_d  = buf_mid | ({bus.in_data, {(BUF_W-IN_W){1'b0}}} >> fill_mid);
            fill_d = fill_mid + FILL_W'(IN_W);
        end

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_len_d   = out_len_q;
        if (retire) begin
            out_valid_d = 1'b0;
        end
        if (fire) begin
            out_valid_d = 1'b1;
            out_data_d  = dec_val;
            out_len_d   = dec_len;
        end

        sym_count_d = sym_count_q + CNT_W'(retire);
        err_d       = err_q || err_set;

        if (state_q == S_ERROR || err_set) begin
            state_d = S_ERROR;
        end else if (out_valid_q && !bus.out_ready) begin
            state_d = S_HOLD;
        end else if (fill_d != '0) begin
            state_d = S_DECODE;
        end else begin
            state_d = S_IDLE;
        end

        if (flush) begin
            buf_d       = '0;
            fill_d      = '0;
            err_d       = 1'b0;
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
        end

        in_ready_d = (state_d != S_ERROR) && (int'(fill_d) <= BUF_W - IN_W);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            buf_q       <= '0;
            fill_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_len_q   <= '0;
            err_q       <= 1'b0;
            sym_count_q <= '0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            fill_q      <= fill_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_len_q   <= out_len_d;
            err_q       <= err_d;
            sym_count_q <= sym_count_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_len   = out_len_q;
    assign err           = err_q;
    assign fill_level    = fill_q;
    assign sym_count     = sym_count_q;

endmodule

// File: tb/tb_egd_stream_decoder.sv
// Directed bench for egd_stream_decoder: each scenario task drives vectors and
// compares outputs against hand-derived values.
module tb_egd_stream_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic [31:0] te_range;
    logic [4:0]  fixed_len;
    logic        flush;
    logic        err;
    logic [6:0]  fill_level;
    logic [15:0] sym_count;

    int checks = 0;
    int passes = 0;

    egd_stream_decoder_if #(.IN_W(16), .OUT_W(32)) bus ();

    egd_stream_decoder #(
        .IN_W(16), .BUF_W(64), .MAX_LZ(15), .OUT_W(32), .CNT_W(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .mode       (mode),
        .te_range   (te_range),
        .fixed_len  (fixed_len),
        .flush      (flush),
        .err        (err),
        .fill_level (fill_level),
        .sym_count  (sym_count)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Hard stop in case something hangs outside a bounded wait
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Entered and left at a falling edge; the word is taken on the rising edge in between
    task automatic push_word(input logic [15:0] w);
        bus.in_data  = w;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready); else passes++;
        checks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid); else passes++;
        checks++; if (bus.out_data !== 32'h0) $display("[TB] FAIL reset_out_data: got %h expected 0", bus.out_data); else passes++;
        checks++; if (bus.out_len !== 6'd0) $display("[TB] FAIL reset_out_len: got %0d expected 0", bus.out_len); else passes++;
        checks++; if (err !== 1'b0) $display("[TB] FAIL reset_err: got %b expected 0", err); else passes++;
        checks++; if (fill_level !== 7'd0) $display("[TB] FAIL reset_fill: got %0d expected 0", fill_level); else passes++;
        checks++; if (sym_count !== 16'd0) $display("[TB] FAIL reset_sym_count: got %0d expected 0", sym_count); else passes++;
        rst = 1'b0;
    endtask

    // 0xA641 = 1 | 010 | 011 | 00100 | 0001 -> ue 0,1,2,3 on consecutive cycles
    task automatic test_ue_back_to_back();
        logic [31:0] exp_d [4];
        logic [5:0]  exp_l [4];
        exp_d = '{32'd0, 32'd1, 32'd2, 32'd3};
        exp_l = '{6'd1, 6'd3, 6'd3, 6'd5};
        mode = 2'b00;
        bus.out_ready = 1'b1;
        push_word(16'hA641);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== exp_d[k] || bus.out_len !== exp_l[k])
                $display("[TB] FAIL ue_sym%0d: got valid=%b data=%h len=%0d expected valid=1 data=%h len=%0d",
                         k, bus.out_valid, bus.out_data, bus.out_len, exp_d[k], exp_l[k]);
            else passes++;
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || fill_level !== 7'd4)
            $display("[TB] FAIL ue_tail: got valid=%b fill=%0d expected valid=0 fill=4", bus.out_valid, fill_level);
        else passes++;
        checks++; if (sym_count !== 16'd4) $display("[TB] FAIL ue_sym_count: got %0d expected 4", sym_count); else passes++;
        // "0001" + "1000..." -> N=3, info=100 -> 2^3-1+4 = 11, length 7
        push_word(16'h8000);
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'd11 || bus.out_len !== 6'd7)
            $display("[TB] FAIL ue_straddle: got valid=%b data=%h len=%0d expected valid=1 data=0000000b len=7",
                     bus.out_valid, bus.out_data, bus.out_len);
        else passes++;
        do_flush();
        checks++; if (fill_level !== 7'd0) $display("[TB] FAIL ue_flush_fill: got %0d expected 0", fill_level); else passes++;
    endtask

    task automatic test_se();
        logic [31:0] exp_d [4];
        logic [5:0]  exp_l [4];
        exp_d = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0002};
        exp_l = '{6'd1, 6'd3, 6'd3, 6'd5};
        mode = 2'b01;
        bus.out_ready = 1'b1;
        push_word(16'hA641);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== exp_d[k] || bus.out_len !== exp_l[k])
                $display("[TB] FAIL se_sym%0d: got valid=%b data=%h len=%0d expected valid=1 data=%h len=%0d",
                         k, bus.out_valid, bus.out_data, bus.out_len, exp_d[k], exp_l[k]);
            else passes++;
        end
        do_flush();
    endtask

    task automatic test_te();
        bit ok;
        mode = 2'b10;
        te_range = 32'd1;
        bus.out_ready = 1'b0;
        push_word(16'h4000);
        wait_valid(ok);
        checks++; if (!ok) $display("[TB] FAIL te1_timeout: got no out_valid expected out_valid=1"); else passes++;
        checks++;
        if (bus.out_data !== 32'd1 || bus.out_len !== 6'd1)
            $display("[TB] FAIL te1_first: got data=%h len=%0d expected data=1 len=1", bus.out_data, bus.out_len);
        else passes++;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'd0 || bus.out_len !== 6'd1)
            $display("[TB] FAIL te1_second: got valid=%b data=%h len=%0d expected valid=1 data=0 len=1",
                     bus.out_valid, bus.out_data, bus.out_len);
        else passes++;
        // A word offered in the flush cycle must be dropped
        bus.in_data  = 16'hFFFF;
        bus.in_valid = 1'b1;
        flush        = 1'b1;
        @(negedge clk);
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if (fill_level !== 7'd0 || bus.out_valid !== 1'b0)
            $display("[TB] FAIL flush_drops_word: got fill=%0d valid=%b expected fill=0 valid=0", fill_level, bus.out_valid);
        else passes++;
        te_range = 32'd5;
        push_word(16'h4000);
        wait_valid(ok);
        checks++;
        if (!ok || bus.out_data !== 32'd1 || bus.out_len !== 6'd3)
            $display("[TB] FAIL te5: got valid=%b data=%h len=%0d expected valid=1 data=1 len=3",
                     bus.out_valid, bus.out_data, bus.out_len);
        else passes++;
        do_flush();
    endtask

    task automatic test_fixed_len();
        bit ok;
        mode = 2'b11;
        fixed_len = 5'd12;
        bus.out_ready = 1'b0;
        push_word(16'hABCD);
        wait_valid(ok);
        checks++;
        if (!ok || bus.out_data !== 32'h0ABC || bus.out_len !== 6'd12)
            $display("[TB] FAIL u12_first: got valid=%b data=%h len=%0d expected valid=1 data=00000abc len=12",
                     bus.out_valid, bus.out_data, bus.out_len);
        else passes++;
        checks++; if (fill_level !== 7'd4) $display("[TB] FAIL u12_fill: got %0d expected 4", fill_level); else passes++;
        push_word(16'h1234);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h0D12 || bus.out_len !== 6'd12)
            $display("[TB] FAIL u12_second: got valid=%b data=%h len=%0d expected valid=1 data=00000d12 len=12",
                     bus.out_valid, bus.out_data, bus.out_len);
        else passes++;
        do_flush();
        // Out-of-range lengths decode a single bit
        fixed_len = 5'd0;
        push_word(16'h8000);
        wait_valid(ok);
        checks++;
        if (!ok || bus.out_data !== 32'd1 || bus.out_len !== 6'd1)
            $display("[TB] FAIL u0_as_u1: got valid=%b data=%h len=%0d expected valid=1 data=1 len=1",
                     bus.out_valid, bus.out_data, bus.out_len);
        else passes++;
        fixed_len = 5'd20;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'd0 || bus.out_len !== 6'd1)
            $display("[TB] FAIL u20_as_u1: got valid=%b data=%h len=%0d expected valid=1 data=0 len=1",
                     bus.out_valid, bus.out_data, bus.out_len);
        else passes++;
        do_flush();
    endtask

    task automatic test_error();
        mode = 2'b00;
        bus.out_ready = 1'b0;
        push_word(16'h0000);
        @(negedge clk);
        checks++;
        if (err !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0)
            $display("[TB] FAIL err_set: got err=%b in_ready=%b valid=%b expected err=1 in_ready=0 valid=0",
                     err, bus.in_ready, bus.out_valid);
        else passes++;
        repeat (3) @(negedge clk);
        checks++;
        if (err !== 1'b1 || bus.out_valid !== 1'b0)
            $display("[TB] FAIL err_sticky: got err=%b valid=%b expected err=1 valid=0", err, bus.out_valid);
        else passes++;
        do_flush();
        checks++;
        if (err !== 1'b0 || fill_level !== 7'd0 || bus.in_ready !== 1'b1)
            $display("[TB] FAIL err_flush: got err=%b fill=%0d in_ready=%b expected err=0 fill=0 in_ready=1",
                     err, fill_level, bus.in_ready);
        else passes++;
    endtask

    // 0x5000 = 010 | 1 | zeros -> two ue symbols (1, len 3) then (0, len 1)
    task automatic test_back_pressure();
        bit ok;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mode = 2'b00;
        bus.out_ready = 1'b0;
        push_word(16'h5000);
        wait_valid(ok);
        checks++;
        if (!ok || bus.out_data !== 32'd1 || bus.out_len !== 6'd3)
            $display("[TB] FAIL bp_first: got valid=%b data=%h len=%0d expected valid=1 data=1 len=3",
                     bus.out_valid, bus.out_data, bus.out_len);
        else passes++;
        repeat (4) @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'd1 || bus.out_len !== 6'd3 || sym_count !== 16'd0)
            $display("[TB] FAIL bp_hold: got valid=%b data=%h len=%0d sym=%0d expected valid=1 data=1 len=3 sym=0",
                     bus.out_valid, bus.out_data, bus.out_len, sym_count);
        else passes++;
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'd0 || bus.out_len !== 6'd1 || sym_count !== 16'd1)
            $display("[TB] FAIL bp_release1: got valid=%b data=%h len=%0d sym=%0d expected valid=1 data=0 len=1 sym=1",
                     bus.out_valid, bus.out_data, bus.out_len, sym_count);
        else passes++;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || sym_count !== 16'd2)
            $display("[TB] FAIL bp_release2: got valid=%b sym=%0d expected valid=0 sym=2", bus.out_valid, sym_count);
        else passes++;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (fill_level !== 7'd0) $display("[TB] FAIL rst_drops_partial: got fill=%0d expected 0", fill_level); else passes++;
        push_word(16'h5000);
        wait_valid(ok);
        repeat (2) @(negedge clk);
        bus.out_ready = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b0;
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.out_data, bus.out_len, err, fill_level, sym_count}
            !== {1'b1, 1'b0, 32'h0, 6'h0, 1'b0, 7'h0, 16'h0})
            $display("[TB] FAIL rst_in_hold: got rdy=%b vld=%b data=%h len=%0d err=%b fill=%0d sym=%0d expected rdy=1 vld=0 data=0 len=0 err=0 fill=0 sym=0",
                     bus.in_ready, bus.out_valid, bus.out_data, bus.out_len, err, fill_level, sym_count);
        else passes++;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || fill_level !== 7'd0)
            $display("[TB] FAIL rst_no_result: got valid=%b fill=%0d expected valid=0 fill=0", bus.out_valid, fill_level);
        else passes++;
    endtask

    // Scenario sequence
    initial begin
        rst           = 1'b1;
        mode          = 2'b00;
        te_range      = 32'd0;
        fixed_len     = 5'd0;
        flush         = 1'b0;
        bus.in_data   = 16'h0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_ue_back_to_back();
        test_se();
        test_te();
        test_fixed_len();
        test_error();
        test_back_pressure();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
